uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receive front end feeding the UART's CPU-side register file.
- Synchronises the asynchronous RX line, detects and validates a start bit, oversamples mid-bit, and deserialises 8N1 frames, LSB first.
- Holds one received byte with a full flag, plus overrun and framing status. The register file reads these and uses them to drive NINT.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Even, >= 4.
- Cycles per half bit = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- rd  input  1  one-cycle strobe: register file has read rx_data
- err_clr  input  1  one-cycle strobe: clear overrun_err and frame_err
- rx_data  output  8  last accepted byte
- rx_full  output  1  rx_data holds an unread byte
- overrun_err  output  1  sticky: a byte arrived while rx_full=1
- frame_err  output  1  sticky: stop bit sampled low
- busy  output  1  high in every state except IDLE

Behaviour:
- Synchroniser: rx passes through a 2-flop synchroniser to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- Reset values: rx_data=0x00, rx_full=0, overrun_err=0, frame_err=0, busy=0. State=IDLE, bit counter=0, cycle counter=0.
- Reset mid-frame aborts the frame and returns to IDLE the next cycle. No status update.
- IDLE:
  - rx_s==0 -> START, cycle counter cleared.
- START:
  - Count 0..CLKS_PER_BIT/2-1.
  - On the last count: rx_s==0 -> DATA, counter=0, bit index=0.
  - Otherwise -> IDLE. This is glitch rejection; no flags change.
- DATA:
  - Count 0..CLKS_PER_BIT-1. On the last count, shift rx_s into shift reg bit [7] (LSB first), right-shifting.
  - After bit index 7 is sampled -> STOP. Otherwise increment the bit index.
- STOP:
  - Count 0..CLKS_PER_BIT-1 and sample rx_s on the last count.
  - rx_s==1, rx_full==0 or rd==1 that cycle: load rx_data, rx_full=1 next cycle, -> IDLE.
  - rx_s==1, rx_full==1, rd==0: byte discarded, rx_data unchanged, overrun_err=1, -> IDLE.
  - rx_s==0: frame_err=1, byte discarded, -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE. A held-low line (break) yields exactly one frame_err and no bytes.
- rx_full:
  - Cleared the cycle after rd.
  - rd together with a load: load wins, rx_full stays 1, no overrun.
  - rd while rx_full==0 has no effect.
- Error flags:
  - err_clr clears both flags next cycle.
  - err_clr together with a new error event: the set wins.
- busy is combinational from state (state != IDLE).
- Frame latency: the stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after rx_s first goes low. rx_full rises one cycle later.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and lasts CLKS_PER_BIT cycles.
  - The sampled bit must make even parity over the 8 data bits plus the parity bit.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by err_clr).
  - On mismatch: parity_err=1, byte still loaded per the STOP rules.
  - Frame latency increases by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
- Basic receive (CLKS_PER_BIT=16): send 0x55 as an 8N1 frame, rd held 0 -> rx_data=0x55, rx_full=1, 154–157 cycles after the rx falling edge. Errors stay 0; busy low afterwards.
- Glitch rejection: rx low for 4 cycles, then high -> returns to IDLE, rx_full stays 0. A following valid 0xA3 frame is received correctly.
- Overrun: frames 0x12 then 0x34 with no rd -> rx_data=0x12, rx_full=1, overrun_err=1. Then rd -> rx_full=0. Then err_clr -> overrun_err=0.
- Read/load collision: rd asserted exactly on the STOP sample cycle of 0x7E while rx_full=1 -> rx_data=0x7E, rx_full=1, overrun_err=0.
- Framing/break: 0xFF frame with stop bit low, rx then held low 40 bit times -> frame_err=1 once, rx_full=0, busy=1 until rx rises. Next 0x00 frame is received OK.
- Reset mid-frame: reset asserted for 1 cycle during data bit 3 -> all outputs at reset values next cycle. A subsequent 0xC9 frame is received correctly.
- Parity (UART_RX_PARITY_EN): 0x01 with parity bit 0 -> parity_err=1, rx_data=0x01. 0x03 with parity bit 0 -> parity_err stays 0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-byte holding register.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       overrun_err,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_full_q, rx_full_d;
    logic            overrun_q, overrun_d;
    logic            frame_q, frame_d;
    logic            rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
`ifdef UART_RX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        // A load in STOP overrides these clears, so set always wins over rd/err_clr.
        rx_full_d = rx_full_q & ~rd;
        overrun_d = overrun_q & ~err_clr;
        frame_d   = frame_q & ~err_clr;
`ifdef UART_RX_PARITY_EN
        parity_d  = parity_q & ~err_clr;
`endif

        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    if (^{shift_q, rx_s_q}) begin
                        parity_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                        if (!rx_full_q || rd) begin
                            rx_data_d = shift_q;
                            rx_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_d = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_full     = rx_full_q;
    assign overrun_err = overrun_q;
    assign frame_err   = frame_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_q;
`endif
    assign busy        = (state_q != StIdle);

endmodule
